// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU execute sequencer: opcodes, branch
// conditions, FSM state encoding and the immediate sign-extension helper.
package seq_defs;

    // Instruction opcode field ir[7:6]
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

    // Branch condition field ir[5:4]
    localparam logic [1:0] C_Z  = 2'b00;
    localparam logic [1:0] C_S  = 2'b01;
    localparam logic [1:0] C_V  = 2'b10;
    localparam logic [1:0] C_AL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Sign-extend a 4-bit immediate to a full data byte
    function automatic logic [7:0] sext4to8(input logic [3:0] v);
        return {{4{v[3]}}, v};
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit registers: two combinational operand read ports, one debug
// read port, one synchronous write port and an asynchronous clear.
module regfile4x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr_a,
    input  logic [1:0] raddr_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    logic [7:0] mem_r [0:3];

    // Register storage: cleared on reset, single write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Reads see the pre-write value, so rd == rs uses the old operand
    assign rdata_a  = mem_r[raddr_a];
    assign rdata_b  = mem_r[raddr_b];
    assign dbg_data = mem_r[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller for an external 8-bit add/sub ALU.
// Fetches over a req/ack handshake, executes each instruction in one cycle,
// latches ALU flags and resolves flag-conditional relative branches.
module alu_sequencer
    import seq_defs::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [7:0]      alu_first,
    output logic [7:0]      alu_second,
    output logic            alu_addSubN,
    input  logic [7:0]      alu_result,
    input  logic            alu_z,
    input  logic            alu_s,
    input  logic            alu_v,
    output logic [2:0]      flags,
    output logic            busy,
    output logic            halted,
    input  logic [1:0]      dbg_sel,
    output logic [7:0]      dbg_data
);

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] ipc_r;
    logic [7:0]      ir_r;
    logic [2:0]      flags_r;
    logic            imem_req_r;
    logic            busy_r;
    logic            halted_r;

    logic [1:0]      op_s;
    logic [1:0]      rd_s;
    logic [1:0]      rs_s;
    logic [1:0]      cond_s;
    logic [PC_W-1:0] br_target_s;
    logic            taken_s;
    logic            halt_s;
    logic            rf_we_s;
    logic [7:0]      rf_wdata_s;

    assign op_s   = ir_r[7:6];
    assign rd_s   = ir_r[5:4];
    assign rs_s   = ir_r[3:2];
    assign cond_s = ir_r[5:4];

    // Branch target is relative to the branch's own address, not pc+1
    assign br_target_s = ipc_r + {{(PC_W-4){ir_r[3]}}, ir_r[3:0]};
    // Unconditional branch to itself is the halt idiom
    assign halt_s      = (op_s == OP_BR) && (cond_s == C_AL) && (ir_r[3:0] == 4'h0);

    // Branch condition select against the latched flags {z,s,v}
    always_comb begin
        taken_s = 1'b0;
        case (cond_s)
            C_Z:     taken_s = flags_r[2];
            C_S:     taken_s = flags_r[1];
            C_V:     taken_s = flags_r[0];
            C_AL:    taken_s = 1'b1;
            default: taken_s = 1'b0;
        endcase
    end

    // Write-back port: only ADD/SUB/LDI in EXEC write the register file
    always_comb begin
        rf_we_s    = 1'b0;
        rf_wdata_s = 8'h00;
        if (state_r == EXEC) begin
            case (op_s)
                OP_ADD, OP_SUB: begin
                    rf_we_s    = 1'b1;
                    rf_wdata_s = alu_result;
                end
                OP_LDI: begin
                    rf_we_s    = 1'b1;
                    rf_wdata_s = sext4to8(ir_r[3:0]);
                end
                default: begin
                    rf_we_s    = 1'b0;
                    rf_wdata_s = 8'h00;
                end
            endcase
        end else begin
            rf_we_s    = 1'b0;
            rf_wdata_s = 8'h00;
        end
    end

    regfile4x8 u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we_s),
        .waddr    (rd_s),
        .wdata    (rf_wdata_s),
        .raddr_a  (rd_s),
        .raddr_b  (rs_s),
        .rdata_a  (alu_first),
        .rdata_b  (alu_second),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    // Sequencer FSM with pc/ir/flags and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            ipc_r      <= RESET_PC;
            ir_r       <= 8'h00;
            flags_r    <= 3'b000;
            imem_req_r <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= FETCH;
                        imem_req_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir_r       <= imem_data;
                        ipc_r      <= pc_r;
                        pc_r       <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                        state_r    <= EXEC;
                        imem_req_r <= 1'b0;
                    end
                end
                EXEC: begin
                    case (op_s)
                        OP_ADD, OP_SUB: flags_r <= {alu_z, alu_s, alu_v};
                        OP_BR: begin
                            if (taken_s) begin
                                pc_r <= br_target_s;
                            end
                        end
                        default: flags_r <= flags_r;
                    endcase
                    if (halt_s) begin
                        state_r    <= HALT;
                        imem_req_r <= 1'b0;
                        busy_r     <= 1'b0;
                        halted_r   <= 1'b1;
                    end else begin
                        state_r    <= FETCH;
                        imem_req_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                HALT: begin
                    if (start) begin
                        pc_r       <= RESET_PC;
                        state_r    <= FETCH;
                        imem_req_r <= 1'b1;
                        busy_r     <= 1'b1;
                        halted_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    imem_req_r <= 1'b0;
                    busy_r     <= 1'b0;
                    halted_r   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = pc_r;
    assign imem_req    = imem_req_r;
    assign alu_addSubN = ~ir_r[6];
    assign flags       = flags_r;
    assign busy        = busy_r;
    assign halted      = halted_r;

endmodule
